// File: rtl/rv_inst_encoder_pkg.sv
// rv_inst_encoder_pkg: shared definitions for the RV32I instruction encoder.
//   - base opcodes of the supported formats
//   - op-class codes 0..7 carried on in_op
//   - canonical NOP word (addi x0, x0, 0)
//   - encoder FSM state encodings
// Optional feature macro used by the encoder files: RV_ENC_IMM_CHECK_EN.
package rv_inst_encoder_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  typedef enum logic [2:0] {
    OP_LOAD   = 3'd0,
    OP_STORE  = 3'd1,
    OP_RTYPE  = 3'd2,
    OP_ITYPE  = 3'd3,
    OP_BRANCH = 3'd4,
    OP_JAL    = 3'd5,
    OP_LUI    = 3'd6,
    OP_NOP    = 3'd7
  } op_class_e;

  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/rv_inst_pack.sv
// rv_inst_pack: purely combinational field-to-word packer for RV32I.
// Ports:
//   op       in  3   op class (see op_class_e)
//   rd/rs1/rs2 in 5  register indices
//   funct3   in  3 ; funct7 in 7
//   imm      in  32  sign-extended byte offset or U-type value
//   inst     out 32  encoded instruction word (immediate truncated to format bits)
//   imm_err  out 1   immediate not representable in the format
// Macro RV_ENC_IMM_CHECK_EN: when defined, imm_err reports range violations;
// otherwise imm_err is constant 0.
module rv_inst_pack
  import rv_inst_encoder_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic [31:0] inst,
  output logic        imm_err
);

  // SLLI/SRLI/SRAI carry funct7 in the upper immediate bits.
  logic is_shift;
  assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

  always_comb begin
    inst = NOP_WORD;
    case (op_class_e'(op))
      OP_LOAD:   inst = {imm[11:0], rs1, funct3, rd, OPC_LOAD};
      OP_STORE:  inst = {imm[11:5], rs2, rs1, funct3, imm[4:0], OPC_STORE};
      OP_RTYPE:  inst = {funct7, rs2, rs1, funct3, rd, OPC_OP};
      OP_ITYPE:  inst = is_shift ? {funct7, imm[4:0], rs1, funct3, rd, OPC_OPIMM}
                                 : {imm[11:0], rs1, funct3, rd, OPC_OPIMM};
      OP_BRANCH: inst = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OPC_BRANCH};
      OP_JAL:    inst = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
      OP_LUI:    inst = {imm[31:12], rd, OPC_LUI};
      default:   inst = NOP_WORD;
    endcase
  end

`ifdef RV_ENC_IMM_CHECK_EN
  // A value fits N signed bits when all bits above N-1 equal the sign bit.
  logic fits12, fits13, fits21;
  assign fits12 = (&imm[31:11]) | ~(|imm[31:11]);
  assign fits13 = (&imm[31:12]) | ~(|imm[31:12]);
  assign fits21 = (&imm[31:20]) | ~(|imm[31:20]);

  always_comb begin
    imm_err = 1'b0;
    case (op_class_e'(op))
      OP_LOAD, OP_STORE: imm_err = ~fits12;
      OP_ITYPE:          imm_err = is_shift ? (|imm[31:5]) : ~fits12;
      OP_BRANCH:         imm_err = ~fits13 | imm[0];
      OP_JAL:            imm_err = ~fits21 | imm[0];
      OP_LUI:            imm_err = |imm[11:0];
      default:           imm_err = 1'b0;
    endcase
  end
`else
  assign imm_err = 1'b0;
`endif

endmodule

// File: rtl/rv_inst_encoder.sv
// rv_inst_encoder: streaming RV32I instruction encoder / program loader.
// Accepts decoded field bundles over valid/ready, packs them into 32-bit
// words and emits each with an auto-incrementing byte address.
// Ports:
//   clk, rst (async, active high), start (pulse: IDLE/DONE -> RUN)
//   in_valid/in_ready/in_last, in_op, in_rd, in_rs1, in_rs2,
//   in_funct3, in_funct7, in_imm     input field bundle
//   out_valid/out_ready, out_inst, out_addr   output word stream
//   count  words emitted since start (saturating)
//   done   one-cycle pulse after the final word is taken
//   err    sticky immediate-range error
// Macro RV_ENC_IMM_CHECK_EN: enables the immediate range check driving err;
// without it err stays 0 and immediates are silently truncated.
module rv_inst_encoder
  import rv_inst_encoder_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [2:0]        in_op,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [31:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_inst,
  output logic [ADDR_W-1:0] out_addr,
  output logic [15:0]       count,
  output logic              done,
  output logic              err
);

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  state_e            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [31:0]       slot0_q, slot0_d, slot1_q, slot1_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       count_q, count_d;
  logic              in_ready_q, in_ready_d;
  logic              err_q, err_d;

  logic [31:0] pack_inst;
  logic        pack_err;
  logic        push, pop, start_ok;

  rv_inst_pack u_pack (
    .op      (in_op),
    .rd      (in_rd),
    .rs1     (in_rs1),
    .rs2     (in_rs2),
    .funct3  (in_funct3),
    .funct7  (in_funct7),
    .imm     (in_imm),
    .inst    (pack_inst),
    .imm_err (pack_err)
  );

  assign push     = in_valid & in_ready_q;
  assign pop      = (cnt_q != 2'd0) & out_ready;
  assign start_ok = start & ((state_q == ST_IDLE) | (state_q == ST_DONE));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; DRAIN exits on the cycle the last word leaves so that
  // done follows the final output handshake directly.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_ok) state_d = ST_RUN;
      ST_RUN:   if (push && in_last) state_d = ST_DRAIN;
      ST_DRAIN: if (cnt_d == 2'd0) state_d = ST_DONE;
      ST_DONE:  state_d = start_ok ? ST_RUN : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Outputs; out_inst reads 0 whenever no word is presented.
  always_comb begin
    done      = (state_q == ST_DONE);
    out_valid = (cnt_q != 2'd0);
    out_inst  = (cnt_q != 2'd0) ? slot0_q : 32'd0;
    out_addr  = addr_q;
    count     = count_q;
    in_ready  = in_ready_q;
    err       = err_q;
  end

  // Skid buffer and counters. slot0 is always the head. in_ready is
  // registered from the next occupancy, so a push can only arrive while
  // at least one slot is free, and occupancy 1 with push+pop keeps
  // in_ready high for full throughput.
  always_comb begin
    cnt_d   = cnt_q + {1'b0, push} - {1'b0, pop};
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    if (pop) slot0_d = slot1_q;
    if (push) begin
      if ((cnt_q - {1'b0, pop}) == 2'd0) slot0_d = pack_inst;
      else                               slot1_d = pack_inst;
    end

    in_ready_d = (state_d == ST_RUN) && (cnt_d != 2'd2);

    addr_d = addr_q;
    if (start_ok)  addr_d = BASE;
    else if (pop)  addr_d = addr_q + ADDR_W'(4);

    count_d = count_q;
    if (start_ok)                         count_d = 16'd0;
    else if (pop && count_q != 16'hFFFF)  count_d = count_q + 16'd1;

    err_d = err_q;
    if (start_ok)              err_d = 1'b0;
    else if (push && pack_err) err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= 2'd0;
      addr_q     <= BASE;
      count_q    <= 16'd0;
      in_ready_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      count_q    <= count_d;
      in_ready_q <= in_ready_d;
      err_q      <= err_d;
    end
  end

  // Buffer payload needs no reset: it is only observed while cnt_q != 0.
  always_ff @(posedge clk) begin
    slot0_q <= slot0_d;
    slot1_q <= slot1_d;
  end

endmodule

// File: tb/tb_rv_inst_encoder.sv
// tb_rv_inst_encoder: scoreboard bench for rv_inst_encoder (ADDR_W=4,
// BASE_ADDR=12 so the address wraps). Reference encoding and immediate
// limits are computed arithmetically from the RV32I format rules.
// Honours RV_ENC_IMM_CHECK_EN for the expected err value.
module tb_rv_inst_encoder;

  localparam int ADDR_W    = 4;
  localparam int BASE_ADDR = 12;

  logic        clk, rst, start, in_valid, in_ready, in_last;
  logic [2:0]  in_op, in_funct3;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [6:0]  in_funct7;
  logic [31:0] in_imm;
  logic        out_valid, out_ready;
  logic [31:0] out_inst;
  logic [ADDR_W-1:0] out_addr;
  logic [15:0] count;
  logic        done, err;

  rv_inst_encoder #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR)) dut (
    .clk(clk), .rst(rst), .start(start),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
    .out_addr(out_addr), .count(count), .done(done), .err(err)
  );

  typedef struct {
    logic [31:0] inst;
    bit          last;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   failures = 0;
  int   exp_addr = BASE_ADDR;
  int   exp_count = 0;
  bit   done_due = 0;
  bit   exp_err = 0;
  int   rdy_mode = 1;  // 0 low, 1 high, 2 random

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #900000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(string name, logic [31:0] act, logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, expv);
    end
  endtask

  task automatic fail_now(string name);
    checks++;
    failures++;
    $display("FAIL %s actual=bound_expired required=event", name);
  endtask

  // Reference encoder: places each field at its bit position arithmetically.
  function automatic logic [31:0] ref_encode(logic [31:0] op, logic [31:0] rd, logic [31:0] rs1,
      logic [31:0] rs2, logic [31:0] f3, logic [31:0] f7, logic [31:0] imm);
    logic [31:0] regs;
    regs = (rs1 << 15) | (f3 << 12);
    case (op)
      0: return ((imm & 32'hfff) << 20) | regs | (rd << 7) | 32'h03;
      1: return (((imm >> 5) & 32'h7f) << 25) | (rs2 << 20) | regs | ((imm & 32'h1f) << 7) | 32'h23;
      2: return (f7 << 25) | (rs2 << 20) | regs | (rd << 7) | 32'h33;
      3: if (f3 == 1 || f3 == 5) return (f7 << 25) | ((imm & 32'h1f) << 20) | regs | (rd << 7) | 32'h13;
         else return ((imm & 32'hfff) << 20) | regs | (rd << 7) | 32'h13;
      4: return (((imm >> 12) & 1) << 31) | (((imm >> 5) & 32'h3f) << 25) | (rs2 << 20) | regs |
                (((imm >> 1) & 32'hf) << 8) | (((imm >> 11) & 1) << 7) | 32'h63;
      5: return (((imm >> 20) & 1) << 31) | (((imm >> 1) & 32'h3ff) << 21) | (((imm >> 11) & 1) << 20) |
                (((imm >> 12) & 32'hff) << 12) | (rd << 7) | 32'h6f;
      6: return (imm & 32'hfffff000) | (rd << 7) | 32'h37;
      default: return 32'h13;
    endcase
  endfunction

  function automatic bit ref_bad(logic [31:0] op, logic [31:0] f3, logic [31:0] imm);
    int s;
    s = $signed(imm);
    case (op)
      0, 1: return (s < -2048) || (s > 2047);
      3: if (f3 == 1 || f3 == 5) return imm > 31;
         else return (s < -2048) || (s > 2047);
      4: return (s < -4096) || (s > 4094) || ((imm & 1) != 0);
      5: return (s < -1048576) || (s > 1048574) || ((imm & 1) != 0);
      6: return (imm & 32'hfff) != 0;
      default: return 0;
    endcase
  endfunction

  // out_ready driver
  initial begin
    out_ready = 0;
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        0: out_ready = 0;
        1: out_ready = 1;
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Monitor: pops the scoreboard on every output handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        sbq.delete();
        exp_addr = BASE_ADDR;
        exp_count = 0;
        done_due = 0;
      end else begin
        if (done_due) begin
          check("done_pulse", done, 1);
          done_due = 0;
        end else if (done) begin
          check("done_spurious", done, 0);
        end
        if (start) begin
          exp_addr = BASE_ADDR;
          exp_count = 0;
        end
        if (out_valid && out_ready) begin
          if (sbq.size() == 0) begin
            check("unexpected_out", out_valid, 0);
          end else begin
            e = sbq.pop_front();
            check("out_inst", out_inst, e.inst);
            check("out_addr", 32'(out_addr), 32'(exp_addr));
            check("count_pre", 32'(count), 32'(exp_count));
            exp_addr = (exp_addr + 4) % (1 << ADDR_W);
            exp_count++;
            if (e.last) done_due = 1;
          end
        end
      end
    end
  end

  // All driver tasks start and end at posedge+#1.
  task automatic pulse_start();
    start = 1;
    exp_err = 0;
    @(posedge clk); #1;
    start = 0;
  endtask

  task automatic send(logic [2:0] op, logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2,
                      logic [2:0] f3, logic [6:0] f7, logic [31:0] imm, bit last,
                      logic [31:0] expw, bit bad);
    int n;
    exp_t e;
    in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7; in_imm = imm; in_last = last;
    in_valid = 1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      fail_now("accept_timeout");
    end else begin
      e.inst = expw;
      e.last = last;
      sbq.push_back(e);
`ifdef RV_ENC_IMM_CHECK_EN
      if (bad) exp_err = 1;
`endif
    end
    @(posedge clk); #1;
    in_valid = 0;
    in_last = 0;
  endtask

  task automatic rand_send(bit last);
    logic [2:0]  op, f3;
    logic [4:0]  rd, rs1, rs2;
    logic [6:0]  f7;
    logic [31:0] imm;
    op = 3'($urandom); f3 = 3'($urandom); f7 = 7'($urandom);
    rd = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
    case (op)
      0, 1: imm = 32'($urandom_range(0, 4095)) - 32'd2048;
      3: if (f3 == 1 || f3 == 5) imm = 32'($urandom_range(0, 31));
         else imm = 32'($urandom_range(0, 4095)) - 32'd2048;
      4: imm = (32'($urandom_range(0, 4095)) - 32'd2048) << 1;
      5: imm = (32'($urandom_range(0, 1048575)) - 32'd524288) << 1;
      6: imm = $urandom & 32'hfffff000;
      default: imm = $urandom;
    endcase
    if ($urandom_range(0, 9) == 0) imm = $urandom;
    send(op, rd, rs1, rs2, f3, f7, imm, last,
         ref_encode(32'(op), 32'(rd), 32'(rs1), 32'(rs2), 32'(f3), 32'(f7), imm),
         ref_bad(32'(op), 32'(f3), imm));
  endtask

  task automatic wait_drain(int nwords);
    int n;
    n = 0;
    while ((sbq.size() != 0 || done_due) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) fail_now("drain_timeout");
    repeat (2) @(negedge clk);
    check("count_end", 32'(count), 32'(nwords));
    check("err_end", 32'(err), 32'(exp_err));
    check("in_ready_idle", 32'(in_ready), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1; start = 0; in_valid = 0; in_last = 0;
    in_op = 0; in_rd = 0; in_rs1 = 0; in_rs2 = 0;
    in_funct3 = 0; in_funct7 = 0; in_imm = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_out_inst", out_inst, 0);
    check("rst_out_addr", 32'(out_addr), BASE_ADDR);
    check("rst_count", 32'(count), 0);
    check("rst_done", 32'(done), 0);
    check("rst_err", 32'(err), 0);
    rst = 0;
    @(posedge clk); #1;

    // Directed formats, full-rate output
    rdy_mode = 1;
    pulse_start();
    send(3, 1, 0, 0, 0, 0, 5, 0, 32'h00500093, 0);
    send(1, 0, 1, 2, 2, 0, 8, 0, 32'h0020A423, 0);
    send(4, 0, 0, 0, 0, 0, -32'sd4, 0, 32'hFE000EE3, 0);
    send(5, 1, 0, 0, 0, 0, 8, 0, 32'h008000EF, 0);
    send(6, 5, 0, 0, 0, 0, 32'h12345000, 0, 32'h123452B7, 0);
    send(2, 3, 1, 2, 0, 0, 32'hdeadbeef, 0, 32'h002081B3, 0);
    send(3, 1, 1, 0, 1, 0, 3, 0, 32'h00309093, 0);
    send(3, 2, 2, 0, 5, 7'h20, 2, 0, 32'h40215113, 0);
    send(0, 5, 2, 0, 2, 0, 32'hffffffff, 0, 32'hFFF12283, 0);
    send(4, 0, 0, 0, 0, 0, 4094, 0, 32'h7E000FE3, 0);
    send(5, 0, 0, 0, 0, 0, 32'hFFF00000, 0, 32'h8000006F, 0);
    send(7, 31, 17, 9, 5, 7'h55, 32'h12345678, 1, 32'h00000013, 0);
    wait_drain(12);

    // Back-pressure: two accepts then in_ready low while stalled
    rdy_mode = 0;
    pulse_start();
    send(3, 1, 0, 0, 0, 0, 5, 0, 32'h00500093, 0);
    send(1, 0, 1, 2, 2, 0, 8, 0, 32'h0020A423, 0);
    in_op = 6; in_rd = 5; in_imm = 32'h12345000; in_valid = 1;
    repeat (4) begin
      @(negedge clk);
      check("stall_in_ready", 32'(in_ready), 0);
    end
    rdy_mode = 1;
    @(posedge clk); #1;
    send(6, 5, 0, 0, 0, 0, 32'h12345000, 1, 32'h123452B7, 0);
    wait_drain(3);

    // Randomized stream with random back-pressure
    rdy_mode = 2;
    pulse_start();
    for (int i = 0; i < 150; i++) rand_send(i == 149);
    wait_drain(150);

    // Out-of-range immediate; word still emitted truncated
    rdy_mode = 1;
    pulse_start();
    send(3, 0, 0, 0, 0, 0, 2048, 1, 32'h80000013, 1);
    wait_drain(1);
    pulse_start();
    @(negedge clk);
    check("err_cleared_by_start", 32'(err), 0);
    @(posedge clk); #1;
    send(7, 0, 0, 0, 0, 0, 0, 1, 32'h00000013, 0);
    wait_drain(1);

    // Reset mid-stream discards buffered words
    rdy_mode = 0;
    pulse_start();
    rand_send(0);
    rand_send(0);
    rst = 1;
    exp_err = 0;
    @(negedge clk);
    check("midrst_out_valid", 32'(out_valid), 0);
    check("midrst_in_ready", 32'(in_ready), 0);
    check("midrst_count", 32'(count), 0);
    @(posedge clk); #1;
    rst = 0;
    rdy_mode = 1;
    repeat (8) @(negedge clk);
    check("post_rst_quiet", 32'(out_valid), 0);
    @(posedge clk); #1;

    // Recovery after reset: three words, last on the third
    pulse_start();
    send(3, 1, 0, 0, 0, 0, 5, 0, 32'h00500093, 0);
    send(1, 0, 1, 2, 2, 0, 8, 0, 32'h0020A423, 0);
    send(4, 0, 0, 0, 0, 0, -32'sd4, 1, 32'hFE000EE3, 0);
    wait_drain(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
